// File: rtl/monkey_pkg.sv
// Shared definitions for the monkey movement controller: state encoding,
// keypad digit codes, HitEdgeCode values and the per-frame event bundle.
package monkey_pkg;

  typedef enum logic [2:0] {
    GROUND   = 3'd0,
    JUMP     = 3'd1,
    FALL     = 3'd2,
    CLIMB    = 3'd3,
    DYING    = 3'd4,
    RESPAWN  = 3'd5,
    GAMEOVER = 3'd6
  } monkey_state_e;

  localparam logic [3:0] DIG_UP    = 4'd8;
  localparam logic [3:0] DIG_DOWN  = 4'd2;
  localparam logic [3:0] DIG_LEFT  = 4'd4;
  localparam logic [3:0] DIG_RIGHT = 4'd6;

  // HitEdgeCode bit order is {left, top, right, bottom}
  localparam logic [3:0] EDGE_LEFT   = 4'b1000;
  localparam logic [3:0] EDGE_TOP    = 4'b0100;
  localparam logic [3:0] EDGE_RIGHT  = 4'b0010;
  localparam logic [3:0] EDGE_BOTTOM = 4'b0001;
  localparam logic [3:0] EDGE_EMBED  = 4'b1111;

  typedef struct packed {
    logic       floorHit;
    logic       embedded;
    logic       ceilHit;
    logic       sideL;
    logic       sideR;
    logic       ladder;
    logic       enemy;
    logic       jumpReq;
    logic [3:0] dirKey;
  } frame_events_t;

  // Clamp a 12-bit intermediate speed into the 11-bit command range.
  function automatic logic signed [10:0] satSpeed(input logic signed [11:0] v);
    if (v > 12'sd1023) begin
      return 11'b011_1111_1111;
    end else if (v < -12'sd1024) begin
      return 11'b100_0000_0000;
    end else begin
      return v[10:0];
    end
  endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Sticky per-frame collision/key flags; at startOfFrame the accumulated set is
// replaced by whatever arrives in that same cycle, so it counts for the next frame.
module frame_event_latch
  import monkey_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          sof_i,
  input  logic          wall_i,
  input  logic [3:0]    hitEdge_i,
  input  logic          ladder_i,
  input  logic          enemy_i,
  input  logic          jump_i,
  input  logic          digitValid_i,
  input  logic [3:0]    digit_i,
  output frame_events_t events_o
);

  frame_events_t ev_q, ev_d, now;

  always_comb begin
    now          = '0;
    now.floorHit = wall_i && ((hitEdge_i == EDGE_BOTTOM) || (hitEdge_i == EDGE_EMBED));
    now.embedded = wall_i && (hitEdge_i == EDGE_EMBED);
    now.ceilHit  = wall_i && (hitEdge_i == EDGE_TOP);
    now.sideL    = wall_i && (hitEdge_i == EDGE_LEFT);
    now.sideR    = wall_i && (hitEdge_i == EDGE_RIGHT);
    now.ladder   = ladder_i;
    now.enemy    = enemy_i;
    now.jumpReq  = jump_i;
    now.dirKey   = digitValid_i ? digit_i : 4'd0;

    if (sof_i) begin
      ev_d = now;
    end else begin
      ev_d        = frame_events_t'(ev_q | now);
      ev_d.dirKey = digitValid_i ? digit_i : ev_q.dirKey;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ev_q <= '0;
    end else begin
      ev_q <= ev_d;
    end
  end

  assign events_o = ev_q;

endmodule

// File: rtl/monkey_state_ctrl.sv
// Frame-rate monkey state controller: decides state and speed commands at each
// startOfFrame. Optional respawn invulnerability: define MONKEY_RESPAWN_INVULN_EN.
module monkey_state_ctrl
  import monkey_pkg::*;
#(
  parameter int X_SPEED        = 40,
  parameter int JUMP_SPEED     = -500,
  parameter int GRAVITY        = 5,
  parameter int MAX_FALL_SPEED = 230,
  parameter int CLIMB_SPEED    = 64,
  parameter int EDGE_PUSH      = 8,
  parameter int DEATH_FRAMES   = 60,
  parameter int INIT_LIVES     = 3
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                startOfFrame,
  input  logic                jumpIsPressed,
  input  logic                digitIsPressed,
  input  logic [3:0]          digit,
  input  logic                wallCollision,
  input  logic                ladderCollision,
  input  logic                enemyCollision,
  input  logic [3:0]          HitEdgeCode,
  output logic signed [10:0]  xSpeedCmd,
  output logic signed [10:0]  ySpeedCmd,
  output logic                freezeMove,
  output logic                respawnPulse,
  output monkey_state_e       monkeyState,
  output logic [1:0]          lives,
  output logic                gameOver,
  output logic                blinkN
);

  localparam logic signed [10:0] XS11     = 11'(X_SPEED);
  localparam logic signed [10:0] CS11     = 11'(CLIMB_SPEED);
  localparam logic signed [10:0] EP11     = 11'(EDGE_PUSH);
  localparam logic signed [11:0] JS12     = 12'(JUMP_SPEED);
  localparam logic signed [11:0] GR12     = 12'(GRAVITY);
  localparam logic signed [11:0] MF12     = 12'(MAX_FALL_SPEED);
  localparam logic [7:0]         DIE_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [1:0]         LIVES0   = 2'(INIT_LIVES);

  frame_events_t ev;

  monkey_state_e     state_q, state_d;
  logic signed [10:0] xSpeed_q, xSpeed_d, ySpeed_q, ySpeed_d;
  logic [1:0]         lives_q, lives_d;
  logic [7:0]         dieCnt_q, dieCnt_d;
  logic               respawn_q, respawn_d;
  logic               enemyEff;

  logic signed [11:0] yGrav, yFall;
  logic signed [10:0] keyX, climbY, groundY;
  logic               moving;

  frame_event_latch uLatch (
    .clk_i        (clk),
    .reset_i      (reset),
    .sof_i        (startOfFrame),
    .wall_i       (wallCollision),
    .hitEdge_i    (HitEdgeCode),
    .ladder_i     (ladderCollision),
    .enemy_i      (enemyCollision),
    .jump_i       (jumpIsPressed),
    .digitValid_i (digitIsPressed),
    .digit_i      (digit),
    .events_o     (ev)
  );

`ifdef MONKEY_RESPAWN_INVULN_EN
  logic [6:0] invuln_q, invuln_d;

  // Invulnerability window opens on leaving RESPAWN and counts down per frame.
  always_comb begin
    invuln_d = invuln_q;
    if (startOfFrame) begin
      if (state_q == RESPAWN) begin
        invuln_d = 7'd90;
      end else if (invuln_q != 7'd0) begin
        invuln_d = invuln_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      invuln_q <= '0;
    end else begin
      invuln_q <= invuln_d;
    end
  end

  assign enemyEff = ev.enemy && (invuln_q == 7'd0);
  assign blinkN   = (invuln_q == 7'd0) || invuln_q[3];
`else
  assign enemyEff = ev.enemy;
  assign blinkN   = 1'b1;
`endif

  always_comb begin
    yGrav   = {ySpeed_q[10], ySpeed_q} + GR12;
    yFall   = (yGrav > MF12) ? MF12 : yGrav;
    groundY = ev.embedded ? -EP11 : 11'sd0;

    // Wall side contact overrides the keypad direction.
    if (ev.sideL && ev.sideR)               keyX = 11'sd0;
    else if (ev.sideL)                      keyX = XS11;
    else if (ev.sideR)                      keyX = -XS11;
    else if (ev.dirKey == DIG_LEFT)         keyX = -XS11;
    else if (ev.dirKey == DIG_RIGHT)        keyX = XS11;
    else                                    keyX = 11'sd0;

    if (ev.dirKey == DIG_UP)                climbY = -CS11;
    else if (ev.dirKey == DIG_DOWN)         climbY = CS11;
    else                                    climbY = 11'sd0;

    state_d   = state_q;
    xSpeed_d  = xSpeed_q;
    ySpeed_d  = ySpeed_q;
    lives_d   = lives_q;
    dieCnt_d  = dieCnt_q;
    respawn_d = 1'b0;
    moving    = 1'b0;

    if (startOfFrame) begin
      unique case (state_q)
        GROUND: begin
          if (enemyEff) state_d = DYING;
          else if (ev.jumpReq) begin
            state_d  = JUMP;
            ySpeed_d = satSpeed(JS12);
          end else if (ev.ladder && ((ev.dirKey == DIG_UP) || (ev.dirKey == DIG_DOWN))) begin
            state_d  = CLIMB;
            ySpeed_d = climbY;
          end else if (!ev.floorHit) begin
            state_d  = FALL;
            ySpeed_d = satSpeed(GR12);
          end else begin
            ySpeed_d = groundY;
          end
        end
        JUMP: begin
          if (enemyEff) state_d = DYING;
          else if (ev.ceilHit) begin
            state_d  = FALL;
            ySpeed_d = 11'sd10;
          end else begin
            if (yGrav >= 12'sd0) state_d = FALL;
            ySpeed_d = satSpeed(yGrav);
          end
        end
        FALL: begin
          if (enemyEff) state_d = DYING;
          else if (ev.floorHit) begin
            state_d  = GROUND;
            ySpeed_d = groundY;
          end else if (ev.ladder) begin
            state_d  = CLIMB;
            ySpeed_d = 11'sd0;
          end else begin
            ySpeed_d = satSpeed(yFall);
          end
        end
        CLIMB: begin
          if (enemyEff) state_d = DYING;
          else if (!ev.ladder) begin
            state_d  = FALL;
            ySpeed_d = 11'sd0;
          end else if (ev.floorHit && (ev.dirKey == DIG_DOWN)) begin
            state_d  = GROUND;
            ySpeed_d = 11'sd0;
          end else if (ev.jumpReq) begin
            state_d  = FALL;
            ySpeed_d = 11'sd0;
          end else begin
            ySpeed_d = climbY;
          end
        end
        DYING: begin
          if (dieCnt_q == DIE_LAST) begin
            lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            state_d = (lives_d == 2'd0) ? GAMEOVER : RESPAWN;
          end else begin
            dieCnt_d = dieCnt_q + 8'd1;
          end
        end
        RESPAWN: begin
          state_d  = FALL;
          ySpeed_d = 11'sd0;
        end
        GAMEOVER: begin
          state_d = GAMEOVER;
        end
        default: state_d = FALL;
      endcase

      if ((state_d == DYING) && (state_q != DYING)) dieCnt_d = 8'd0;
      respawn_d = (state_d == RESPAWN) && (state_q != RESPAWN);

      moving   = (state_d == GROUND) || (state_d == JUMP) || (state_d == FALL) || (state_d == CLIMB);
      xSpeed_d = moving ? keyX : 11'sd0;
      if (!moving) ySpeed_d = 11'sd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FALL;
      xSpeed_q  <= '0;
      ySpeed_q  <= '0;
      lives_q   <= LIVES0;
      dieCnt_q  <= '0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      xSpeed_q  <= xSpeed_d;
      ySpeed_q  <= ySpeed_d;
      lives_q   <= lives_d;
      dieCnt_q  <= dieCnt_d;
      respawn_q <= respawn_d;
    end
  end

  assign xSpeedCmd    = xSpeed_q;
  assign ySpeedCmd    = ySpeed_q;
  assign monkeyState  = state_q;
  assign lives        = lives_q;
  assign respawnPulse = respawn_q;
  assign freezeMove   = (state_q == DYING) || (state_q == GAMEOVER);
  assign gameOver     = (state_q == GAMEOVER);

endmodule

// File: tb/tb_monkey_state_ctrl.sv
// Self-checking bench for monkey_state_ctrl: directed frame sequences plus a
// randomized phase, all predicted by a frame-level behavioural model.
module tb_monkey_state_ctrl;
  import monkey_pkg::*;

  logic clk = 1'b0;
  logic reset, startOfFrame, jumpIsPressed, digitIsPressed;
  logic wallCollision, ladderCollision, enemyCollision;
  logic [3:0] digit, HitEdgeCode;
  logic signed [10:0] xSpeedCmd, ySpeedCmd;
  logic freezeMove, respawnPulse, gameOver, blinkN;
  monkey_state_e monkeyState;
  logic [1:0] lives;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  monkey_state_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .jumpIsPressed   (jumpIsPressed),
    .digitIsPressed  (digitIsPressed),
    .digit           (digit),
    .wallCollision   (wallCollision),
    .ladderCollision (ladderCollision),
    .enemyCollision  (enemyCollision),
    .HitEdgeCode     (HitEdgeCode),
    .xSpeedCmd       (xSpeedCmd),
    .ySpeedCmd       (ySpeedCmd),
    .freezeMove      (freezeMove),
    .respawnPulse    (respawnPulse),
    .monkeyState     (monkeyState),
    .lives           (lives),
    .gameOver        (gameOver),
    .blinkN          (blinkN)
  );

  // One frame's worth of stimulus events.
  typedef struct packed {
    bit       floor;
    bit       embed;
    bit       ceil;
    bit       sL;
    bit       sR;
    bit       lad;
    bit       en;
    bit       jmp;
    bit [3:0] dig;
  } ev_t;

  // Behavioural model state, expressed in game terms.
  monkey_state_e mState;
  int  mX, mY, mLives, mDeadFrames, mShield;
  bit  mResp;
  bit  fFloor, fEmb, fCeil, fL, fR, fLad, fEn, fJmp;
  int  fDir;

  function automatic ev_t mk(bit fl, bit em, bit ce, bit sl, bit sr, bit la, bit en, bit jm, int dg);
    ev_t e;
    e.floor = fl; e.embed = em; e.ceil = ce; e.sL = sl; e.sR = sr;
    e.lad = la; e.en = en; e.jmp = jm; e.dig = 4'(dg);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearFlags();
    fFloor = 0; fEmb = 0; fCeil = 0; fL = 0; fR = 0; fLad = 0; fEn = 0; fJmp = 0; fDir = 0;
  endtask

  task automatic modelReset();
    mState = FALL; mX = 0; mY = 0; mLives = 3; mDeadFrames = 0; mShield = 0; mResp = 0;
    clearFlags();
  endtask

  function automatic bool_moving(monkey_state_e s);
    return (s == GROUND) || (s == JUMP) || (s == FALL) || (s == CLIMB);
  endfunction

  // Frame decision computed from the accumulated frame events.
  task automatic modelStep();
    monkey_state_e prev;
    int  keyX, climbV;
    bit  hostile;
    prev    = mState;
    mResp   = 0;
    hostile = fEn;
`ifdef MONKEY_RESPAWN_INVULN_EN
    if (mShield > 0) hostile = 0;
`endif
    keyX = (fDir == 4) ? -40 : (fDir == 6) ? 40 : 0;
    if (fL || fR) keyX = (fL ? 40 : 0) + (fR ? -40 : 0);
    climbV = (fDir == 8) ? -64 : (fDir == 2) ? 64 : 0;

    if (bool_moving(mState) && hostile) begin
      mState = DYING;
      mDeadFrames = 0;
    end else begin
      case (mState)
        GROUND:
          if (fJmp) begin mState = JUMP; mY = -500; end
          else if (fLad && (fDir == 8 || fDir == 2)) begin mState = CLIMB; mY = climbV; end
          else if (!fFloor) begin mState = FALL; mY = 5; end
          else mY = fEmb ? -8 : 0;
        JUMP:
          if (fCeil) begin mState = FALL; mY = 10; end
          else begin mY = mY + 5; if (mY >= 0) mState = FALL; end
        FALL:
          if (fFloor) begin mState = GROUND; mY = fEmb ? -8 : 0; end
          else if (fLad) begin mState = CLIMB; mY = 0; end
          else mY = (mY + 5 > 230) ? 230 : mY + 5;
        CLIMB:
          if (!fLad) begin mState = FALL; mY = 0; end
          else if (fFloor && fDir == 2) begin mState = GROUND; mY = 0; end
          else if (fJmp) begin mState = FALL; mY = 0; end
          else mY = climbV;
        DYING: begin
          mDeadFrames++;
          if (mDeadFrames == 60) begin
            if (mLives > 0) mLives--;
            mState = (mLives == 0) ? GAMEOVER : RESPAWN;
            mResp  = (mState == RESPAWN);
          end
        end
        RESPAWN: begin mState = FALL; mY = 0; end
        default: mState = mState;
      endcase
    end
`ifdef MONKEY_RESPAWN_INVULN_EN
    if (prev == RESPAWN) mShield = 90;
    else if (mShield > 0) mShield--;
`endif
    if (bool_moving(mState)) mX = keyX;
    else begin mX = 0; mY = 0; end
  endtask

  task automatic checkOutput();
    chk("state", monkeyState, mState);
    chk("xSpeed", xSpeedCmd, mX);
    chk("ySpeed", ySpeedCmd, mY);
    chk("lives", lives, mLives);
    chk("gameOver", gameOver, (mState == GAMEOVER));
    chk("freeze", freezeMove, (mState == DYING) || (mState == GAMEOVER));
    chk("respawnPulse", respawnPulse, mResp);
`ifdef MONKEY_RESPAWN_INVULN_EN
    if (mShield == 0) chk("blinkN", blinkN, 1);
`else
    chk("blinkN", blinkN, 1);
`endif
  endtask

  task automatic pulseWall(input logic [3:0] code);
    wallCollision = 1'b1; HitEdgeCode = code;
    tick();
    wallCollision = 1'b0; HitEdgeCode = 4'd0;
    repeat ($urandom_range(0, 1)) tick();
  endtask

  task automatic pulseSig(input int which);
    case (which)
      0: ladderCollision = 1'b1;
      1: enemyCollision  = 1'b1;
      default: jumpIsPressed = 1'b1;
    endcase
    tick();
    ladderCollision = 1'b0; enemyCollision = 1'b0; jumpIsPressed = 1'b0;
    repeat ($urandom_range(0, 1)) tick();
  endtask

  // Drives one frame of events, then the startOfFrame pulse, then checks.
  task automatic applyStimulus(input ev_t e, input bit enemyAtSof);
    digitIsPressed = (e.dig != 4'd0);
    digit          = e.dig;
    repeat ($urandom_range(0, 2)) tick();
    if (e.floor) pulseWall(EDGE_BOTTOM);
    if (e.embed) pulseWall(EDGE_EMBED);
    if (e.ceil)  pulseWall(EDGE_TOP);
    if (e.sL)    pulseWall(EDGE_LEFT);
    if (e.sR)    pulseWall(EDGE_RIGHT);
    if (e.lad)   pulseSig(0);
    if (e.en)    pulseSig(1);
    if (e.jmp)   pulseSig(2);
    tick();
    fFloor |= e.floor | e.embed; fEmb |= e.embed; fCeil |= e.ceil;
    fL |= e.sL; fR |= e.sR; fLad |= e.lad; fEn |= e.en; fJmp |= e.jmp;
    if (e.dig != 4'd0) fDir = e.dig;

    digitIsPressed = 1'b0;
    digit          = 4'd0;
    startOfFrame   = 1'b1;
    enemyCollision = enemyAtSof;
    tick();
    startOfFrame   = 1'b0;
    enemyCollision = 1'b0;
    modelStep();
    clearFlags();
    if (enemyAtSof) fEn = 1;
    checkOutput();
    tick();
    chk("respawnWidth", respawnPulse, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    modelReset();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    ev_t none, fl, e;
    int  digs[6] = '{0, 2, 4, 6, 8, 5};
    none = '0;
    fl   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1; startOfFrame = 1'b0; jumpIsPressed = 1'b0; digitIsPressed = 1'b0;
    digit = 4'd0; wallCollision = 1'b0; ladderCollision = 1'b0; enemyCollision = 1'b0;
    HitEdgeCode = 4'd0;

    doReset();
    chk("rst_state", monkeyState, FALL);
    chk("rst_lives", lives, 3);
    checkOutput();

    applyStimulus(fl, 0);
    chk("land_state", monkeyState, GROUND);

    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 1, 0), 0);
    chk("jump_y0", ySpeedCmd, -500);
    applyStimulus(fl, 0);
    chk("jump_y1", ySpeedCmd, -495);
    repeat (98) applyStimulus(fl, 0);
    chk("jump_still", monkeyState, JUMP);
    applyStimulus(fl, 0);
    chk("jump_apex", monkeyState, FALL);
    applyStimulus(fl, 0);
    chk("jump_land", ySpeedCmd, 0);

    repeat (61) applyStimulus(none, 0);
    chk("fall_sat", ySpeedCmd, 230);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    chk("embed_y", ySpeedCmd, -8);

    applyStimulus(mk(1, 0, 0, 0, 1, 0, 0, 0, 6), 0);
    chk("sideR_x", xSpeedCmd, -40);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 6), 0);
    chk("right_x", xSpeedCmd, 40);

    applyStimulus(mk(1, 0, 0, 0, 0, 1, 0, 0, 8), 0);
    chk("climb_y", ySpeedCmd, -64);
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 8), 0);
    applyStimulus(none, 0);
    chk("ladder_off", monkeyState, FALL);
    applyStimulus(fl, 0);

    applyStimulus(fl, 1);
    chk("sof_enemy_defer", monkeyState, GROUND);
    applyStimulus(fl, 0);
    chk("sof_enemy_next", monkeyState, DYING);

    for (int k = 0; k < 3; k++) begin
      repeat (59) applyStimulus(none, 0);
      chk("still_dying", monkeyState, DYING);
      applyStimulus(none, 0);
      chk("lives_after", lives, 2 - k);
      if (k < 2) begin
        chk("respawn_state", monkeyState, RESPAWN);
        applyStimulus(fl, 0);
        applyStimulus(fl, 0);
`ifdef MONKEY_RESPAWN_INVULN_EN
        repeat (8) applyStimulus(fl, 0);
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), 0);
        chk("invuln_ignore", monkeyState, GROUND);
        repeat (90) applyStimulus(fl, 0);
`endif
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), 0);
        chk("enemy_dies", monkeyState, DYING);
      end else begin
        chk("game_over", gameOver, 1);
      end
    end
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 1, 6), 0);
    chk("gameover_stays", monkeyState, GAMEOVER);

    doReset();
    for (int n = 0; n < 80; n++) begin
      e       = '0;
      e.floor = ($urandom_range(0, 3) != 0);
      e.embed = ($urandom_range(0, 9) == 0);
      e.ceil  = ($urandom_range(0, 7) == 0);
      e.sL    = ($urandom_range(0, 7) == 0);
      e.sR    = ($urandom_range(0, 7) == 0);
      e.lad   = ($urandom_range(0, 3) == 0);
      e.en    = ($urandom_range(0, 24) == 0);
      e.jmp   = ($urandom_range(0, 5) == 0);
      e.dig   = 4'(digs[$urandom_range(0, 5)]);
      applyStimulus(e, ($urandom_range(0, 15) == 0));
    end

    doReset();
    applyStimulus(fl, 0);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), 0);
    repeat (5) applyStimulus(none, 0);
    chk("pre_reset_dying", monkeyState, DYING);
    reset = 1'b1;
    #2;
    chk("async_rst_state", monkeyState, FALL);
    chk("async_rst_lives", lives, 3);
    chk("async_rst_freeze", freezeMove, 0);
    tick();
    reset = 1'b0;
    tick();
    modelReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/monkey_state_ctrl.md
Name: monkey_state_ctrl

Overview:
Frame-rate state controller that sequences the monkey's movement datapath. It latches collision and key events during each frame. At startOfFrame it decides the monkey's state (ground, jump, fall, climb, dying, respawn, game over) and issues signed X/Y speed commands, plus freeze and respawn controls, to the position integrator. It sits between the keypad/collision logic and the monkey position/drawing blocks, and owns the lives count.

Parameters:
X_SPEED, 40, horizontal speed magnitude, 1/64 px per frame
JUMP_SPEED, -500, Y speed loaded on jump (negative = up)
GRAVITY, 5, Y speed increment per frame in JUMP/FALL
MAX_FALL_SPEED, 230, Y speed saturation while falling
CLIMB_SPEED, 64, Y speed magnitude on ladder
EDGE_PUSH, 8, upward push when embedded in floor (HitEdgeCode 1111)
DEATH_FRAMES, 60, frames spent in DYING
INIT_LIVES, 3, lives after reset (1..3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
jumpIsPressed  in  1  jump key level
digitIsPressed  in  1  keypad digit valid
digit  in  4  keypad digit (2 down, 4 left, 6 right, 8 up)
wallCollision  in  1  monkey/wall pixel collision
ladderCollision  in  1  monkey/rope collision
enemyCollision  in  1  monkey/enemy collision
HitEdgeCode  in  4  edge bits {left,top,right,bottom}
xSpeedCmd  out  11 signed  X speed to integrator
ySpeedCmd  out  11 signed  Y speed to integrator
freezeMove  out  1  integrator holds position
respawnPulse  out  1  one clk: integrator reloads initial position
monkeyState  out  3  current state (package enum)
lives  out  2  remaining lives
gameOver  out  1  high in GAMEOVER
blinkN  out  1  draw enable during invulnerability (see option)

Behaviour:
- Reset: state FALL; xSpeedCmd=0; ySpeedCmd=0; freezeMove=0; respawnPulse=0; lives=INIT_LIVES; gameOver=0; blinkN=1; all latches clear.
- Event latches are sticky OR over the frame:
  - floorHit: wallCollision with HitEdgeCode 0001 or 1111; embedded is set when the code is 1111.
  - ceilHit: code 0100. sideL: code 1000. sideR: code 0010.
  - ladder, enemy, jumpReq.
  - dirKey: last digit seen while digitIsPressed.
- At startOfFrame: evaluate from latched values, update state and outputs on the same edge (outputs valid the cycle after the pulse), then clear the latches. An event arriving in the startOfFrame cycle itself goes to the next frame.
- X, all states except DYING/GAMEOVER/RESPAWN:
  - sideL gives +X_SPEED; sideR gives -X_SPEED; both give 0.
  - Otherwise dirKey 4 gives -X_SPEED, 6 gives +X_SPEED, else 0.
- Transitions; enemy has priority in every moving state and goes to DYING:
  - GROUND: jumpReq goes to JUMP with y=JUMP_SPEED. Else ladder and dirKey 8 or 2 goes to CLIMB. Else !floorHit goes to FALL with y=GRAVITY. Else stay with y = embedded ? -EDGE_PUSH : 0.
  - JUMP: ceilHit goes to FALL with y=10. Else y+GRAVITY>=0 goes to FALL. Else y+=GRAVITY.
  - FALL: floorHit goes to GROUND with y = embedded ? -EDGE_PUSH : 0. Else ladder goes to CLIMB with y=0. Else y=min(y+GRAVITY, MAX_FALL_SPEED).
  - CLIMB: !ladder goes to FALL. floorHit and dirKey 2 goes to GROUND. jumpReq goes to FALL with y=0. Else dirKey 8 gives -CLIMB_SPEED, 2 gives +CLIMB_SPEED, other gives 0.
  - DYING: freezeMove=1, x=y=0, frame counter counts DEATH_FRAMES. At expiry lives decrements; lives 0 goes to GAMEOVER, else RESPAWN.
  - RESPAWN: respawnPulse high for exactly one clk at entry, speeds 0, next frame goes to FALL.
  - GAMEOVER: freezeMove=1, gameOver=1; absorbing until reset.
- Width rule: internal Y arithmetic uses 12-bit signed; saturate, never wrap.
- The lives decrement never underflows.

Optional Feature:
- Macro MONKEY_RESPAWN_INVULN_EN.
- Defined: after RESPAWN, the enemy latch is ignored for 90 frames; blinkN toggles every 8 frames in that window, else 1.
- Undefined: enemy is honoured from the first frame after RESPAWN; blinkN is tied 1.

Decomposition:
- Shared package monkey_pkg holds:
  - state enum (GROUND, JUMP, FALL, CLIMB, DYING, RESPAWN, GAMEOVER)
  - digit constants (DIG_UP=8, DIG_DOWN=2, DIG_LEFT=4, DIG_RIGHT=6)
  - HitEdgeCode constants (EDGE_LEFT, EDGE_TOP, EDGE_RIGHT, EDGE_BOTTOM, EDGE_EMBED)
- One sub-module, frame_event_latch, holds the sticky per-frame collision/key flags with clear-on-startOfFrame.

Test Plan:
- Standing on floor (floorHit each frame), jumpIsPressed 1 clk: ySpeedCmd=-500, then -495, -490...; FALL after 100 frames; GROUND with 0 on floorHit.
- Free fall 60 frames without floor: ySpeedCmd rises by 5 per frame and saturates at 230; embedded floor hit gives GROUND with ySpeedCmd=-8.
- digit 6 held with sideR latched in the same frame: xSpeedCmd=-40. Next frame with no side hit: +40.
- Ladder plus digit 8 from GROUND: CLIMB with ySpeedCmd=-64. Ladder removed: FALL.
- enemyCollision three times across respawns: DYING for 60 frames each, lives 3 to 2 to 1 to 0, respawnPulse exactly 1 clk twice, then gameOver=1. Reset asserted mid-DYING gives lives=3, state FALL.
- Collision pulse coinciding with startOfFrame: no state change that frame, acted on at the next pulse. With MONKEY_RESPAWN_INVULN_EN, an enemy at respawn+10 frames is ignored.
